// File: rtl/my_full_adder_if.sv
// Bundles the full-adder data inputs, controls and results so that the
// driver and the adder see one named set of signals.
interface my_full_adder_if #(
    parameter int CNT_W = 8
);
    logic             X;
    logic             Y;
    logic             cin;
    logic             serial_en;
    logic             in_valid;
    logic             clear;
    logic             sum;
    logic             cout;
    logic             sum_q;
    logic             cout_q;
    logic             out_valid;
    logic             carry_q;
    logic [CNT_W-1:0] bit_cnt;

    // Driver side: supplies operands and controls, observes results.
    modport master (
        output X, Y, cin, serial_en, in_valid, clear,
        input  sum, cout, sum_q, cout_q, out_valid, carry_q, bit_cnt
    );

    // Adder side.
    modport slave (
        input  X, Y, cin, serial_en, in_valid, clear,
        output sum, cout, sum_q, cout_q, out_valid, carry_q, bit_cnt
    );
endinterface

// File: rtl/my_full_adder.sv
// Single-bit full adder with a combinational result, a registered copy of
// it, and an optional bit-serial mode in which the carry is kept in a
// register between beats and the processed bits are counted.
module my_full_adder #(
    parameter int CNT_W = 8
) (
    input logic           clk,
    input logic           rst,
    my_full_adder_if.slave bus
);

    logic             c_eff;
    logic             sum;
    logic             cout;
    logic             sum_q;
    logic             cout_q;
    logic             vld_q;
    logic             carry_q;
    logic [CNT_W-1:0] bit_cnt;

    // Carry source: stored serial carry or the external carry-in.
    always_comb begin
        c_eff = bus.serial_en ? carry_q : bus.cin;
        sum   = bus.X ^ bus.Y ^ c_eff;
        cout  = (bus.X & bus.Y) | (bus.X & c_eff) | (bus.Y & c_eff);
    end

    // Registered result; loads on valid beats, holds otherwise. The valid
    // flag only marks the cycle right after a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= 1'b0;
            cout_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= bus.in_valid;
            if (bus.in_valid) begin
                sum_q  <= sum;
                cout_q <= cout;
            end
        end
    end

    // Serial state. Clear wins over a serial beat; the result register above
    // still captures that beat using the carry from before the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q <= 1'b0;
            bit_cnt <= '0;
        end else if (bus.clear) begin
            carry_q <= 1'b0;
            bit_cnt <= '0;
        end else if (bus.in_valid && bus.serial_en) begin
            carry_q <= cout;
            bit_cnt <= bit_cnt + 1'b1;  // wraps silently
        end
    end

    assign bus.sum       = sum;
    assign bus.cout      = cout;
    assign bus.sum_q     = sum_q;
    assign bus.cout_q    = cout_q;
    assign bus.out_valid = vld_q;
    assign bus.carry_q   = carry_q;
    assign bus.bit_cnt   = bit_cnt;

endmodule

// File: tb/tb_my_full_adder.sv
// Directed bench for my_full_adder: a default-width instance and a 2-bit
// counter instance are driven with identical stimulus.
module tb_my_full_adder;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    my_full_adder_if #(.CNT_W(8)) bus  ();
    my_full_adder_if #(.CNT_W(2)) bus2 ();

    my_full_adder #(.CNT_W(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
    my_full_adder #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // 10-unit clock, rising at 5, 15, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic x, input logic y, input logic c,
                       input logic se, input logic iv, input logic cl);
        bus.X = x;   bus.Y = y;   bus.cin = c;
        bus.serial_en = se; bus.in_valid = iv; bus.clear = cl;
        bus2.X = x;  bus2.Y = y;  bus2.cin = c;
        bus2.serial_en = se; bus2.in_valid = iv; bus2.clear = cl;
    endtask

    logic [7:0] exp_s;
    logic [7:0] exp_c;
    logic [3:0] ser_x;
    logic [3:0] ser_y;
    logic [3:0] ser_s;
    logic [3:0] ser_co;
    logic [7:0] wrap_cnt;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        // sum/cout for (X,Y,cin) = 000..111, index = {X,Y,cin}
        exp_s = 8'b1001_0110;
        exp_c = 8'b1110_1000;
        // 0011 + 0001, beats LSB first
        ser_x  = 4'b0011;
        ser_y  = 4'b0001;
        ser_s  = 4'b0100;
        ser_co = 4'b0011;
        wrap_cnt = {2'd0, 2'd3, 2'd2, 2'd1};

        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0);
        #3;
        chk("rst_sum_q",     bus.sum_q,     0);
        chk("rst_cout_q",    bus.cout_q,    0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_carry_q",   bus.carry_q,   0);
        chk("rst_bit_cnt",   bus.bit_cnt,   0);

        // Exhaustive parallel table
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            drv(v[2], v[1], v[0], 0, 1, 0);
            #1;
            chk($sformatf("par_sum_%0d", i),  bus.sum,  exp_s[i]);
            chk($sformatf("par_cout_%0d", i), bus.cout, exp_c[i]);
            @(negedge clk);
            chk($sformatf("par_sum_q_%0d", i),  bus.sum_q,     exp_s[i]);
            chk($sformatf("par_cout_q_%0d", i), bus.cout_q,    exp_c[i]);
            chk($sformatf("par_vld_%0d", i),    bus.out_valid, 1);
            chk($sformatf("par_cnt_%0d", i),    bus.bit_cnt,   0);
        end

        // Idle gap: hold last result (1/1), valid low
        drv(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("gap_vld",    bus.out_valid, 0);
            chk("gap_sum_q",  bus.sum_q,     1);
            chk("gap_cout_q", bus.cout_q,    1);
        end

        // Serial 0011 + 0001
        drv(0, 0, 0, 1, 0, 1);
        @(negedge clk);
        chk("clr_carry", bus.carry_q, 0);
        chk("clr_cnt",   bus.bit_cnt, 0);
        chk("clr_cnt2",  bus2.bit_cnt, 0);
        for (int i = 0; i < 4; i++) begin
            drv(ser_x[i], ser_y[i], 0, 1, 1, 0);
            @(negedge clk);
            chk($sformatf("ser_sum_q_%0d", i), bus.sum_q,   ser_s[i]);
            chk($sformatf("ser_carry_%0d", i), bus.carry_q, ser_co[i]);
            chk($sformatf("ser_cnt_%0d", i),   bus.bit_cnt, i + 1);
            chk($sformatf("wrap_cnt2_%0d", i), bus2.bit_cnt, wrap_cnt[2*i +: 2]);
        end

        // Fifth serial beat sets carry; the 2-bit counter comes back to 1
        drv(1, 1, 0, 1, 1, 0);
        @(negedge clk);
        chk("set_carry", bus.carry_q, 1);
        chk("set_cnt",   bus.bit_cnt, 5);
        chk("wrap_cnt2_4", bus2.bit_cnt, 1);

        // Mode switch acts combinationally and leaves carry_q alone
        drv(1, 0, 0, 0, 0, 0);
        #1;
        chk("mode_par_sum",  bus.sum,  1);
        chk("mode_par_cout", bus.cout, 0);
        drv(1, 0, 0, 1, 0, 0);
        #1;
        chk("mode_ser_sum",  bus.sum,  0);
        chk("mode_ser_cout", bus.cout, 1);
        @(negedge clk);
        chk("mode_carry_kept", bus.carry_q, 1);

        // Clear together with a valid beat uses the old carry
        drv(1, 1, 0, 1, 1, 1);
        #1;
        chk("clrp_sum", bus.sum, 1);
        @(negedge clk);
        chk("clrp_sum_q",  bus.sum_q,     1);
        chk("clrp_cout_q", bus.cout_q,    1);
        chk("clrp_vld",    bus.out_valid, 1);
        chk("clrp_carry",  bus.carry_q,   0);
        chk("clrp_cnt",    bus.bit_cnt,   0);

        // Reset in the middle of a serial add, between edges
        drv(1, 1, 0, 1, 1, 0);
        @(negedge clk);
        chk("pre_rst_carry", bus.carry_q, 1);
        drv(1, 0, 0, 1, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_sum_q",  bus.sum_q,     0);
        chk("mid_rst_cout_q", bus.cout_q,    0);
        chk("mid_rst_carry",  bus.carry_q,   0);
        chk("mid_rst_cnt",    bus.bit_cnt,   0);
        chk("mid_rst_sum",    bus.sum,       1);
        @(negedge clk);
        chk("mid_rst_vld",    bus.out_valid, 0);
        rst = 1'b0;
        drv(1, 0, 0, 1, 1, 0);
        @(negedge clk);
        chk("post_rst_sum_q",  bus.sum_q,     1);
        chk("post_rst_cout_q", bus.cout_q,    0);
        chk("post_rst_vld",    bus.out_valid, 1);
        chk("post_rst_carry",  bus.carry_q,   0);
        chk("post_rst_cnt",    bus.bit_cnt,   1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/my_full_adder.md
MY_FULL_ADDER -- requirements
Module: my_full_adder

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, which sets the width of the serial bit counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have ports X and Y, input, 1 bit each: the addend bits.
REQ-005 The block SHALL have port cin, input, 1 bit: external carry-in, used in parallel mode.
REQ-006 The block SHALL have port serial_en, input, 1 bit: 1 selects bit-serial mode (carry from the internal register), 0 selects parallel mode (carry from cin).
REQ-007 The block SHALL have port in_valid, input, 1 bit: qualifies X, Y and cin for registering.
REQ-008 The block SHALL have port clear, input, 1 bit: synchronous clear of the serial state.
REQ-009 The block SHALL have ports sum and cout, output, 1 bit each: the combinational full-adder result.
REQ-010 The block SHALL have ports sum_q and cout_q, output, 1 bit each: the registered result.
REQ-011 The block SHALL have port out_valid, output, 1 bit: sum_q and cout_q were updated on the previous edge.
REQ-012 The block SHALL have port carry_q, output, 1 bit: the stored serial carry.
REQ-013 The block SHALL have port bit_cnt, output, CNT_W bits: the number of serial bits processed.

Function
REQ-014 c_eff SHALL equal carry_q when serial_en=1 and cin otherwise.
REQ-015 sum SHALL equal X XOR Y XOR c_eff, purely combinational with zero latency and independent of clk and in_valid.
REQ-016 cout SHALL equal (X AND Y) OR (X AND c_eff) OR (Y AND c_eff).
REQ-017 On an edge with in_valid=1, sum_q and cout_q SHALL load the current sum and cout, and out_valid SHALL be 1 for the following cycle, giving 1-cycle latency.
REQ-018 On an edge with in_valid=0, sum_q and cout_q SHALL hold and out_valid SHALL be 0.
REQ-019 On an edge with in_valid=1 and serial_en=1, carry_q SHALL load cout and bit_cnt SHALL increment by 1.
REQ-020 bit_cnt SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-021 On an edge with in_valid=1 and serial_en=0, carry_q and bit_cnt SHALL hold.
REQ-022 On an edge with clear=1, carry_q and bit_cnt SHALL become 0, taking priority over the REQ-019 update.
REQ-023 On a clear edge with simultaneous in_valid=1, sum_q, cout_q and out_valid SHALL still update per REQ-017, using the pre-clear c_eff.
REQ-024 A change of serial_en SHALL take effect combinationally on sum and cout in the same cycle, and SHALL not alter carry_q by itself.
REQ-025 The block SHALL contain no other state, and all arithmetic SHALL be single-bit with no overflow other than cout.

Reset
REQ-026 While rst=1, sum_q, cout_q, out_valid, carry_q and bit_cnt SHALL be 0 immediately, independent of clk.
REQ-027 sum and cout SHALL remain combinational during reset, with carry_q=0 used as the carry when serial_en=1.
REQ-028 Reset asserted mid-serial-operation SHALL discard the stored carry and count, and the first edge after rst deasserts SHALL behave as from the all-zero state.

Verification
REQ-029 Exhaustive parallel test: serial_en=0, apply all 8 combinations of (X,Y,cin) from 000 to 111, each held 10 time units -> sum/cout = 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1, and the same values appear on sum_q/cout_q one edge after each in_valid=1.
REQ-030 Serial add test: serial_en=1, clear, then feed 0011+0001 LSB first (X,Y = 11, 10, 00, 00) with in_valid=1 -> sum_q sequence 0, 0, 1, 0, final carry_q=0, bit_cnt=4.
REQ-031 Clear priority test: carry_q=1, then assert clear and in_valid together with X=Y=1 -> sum_q=1 and cout_q=1 (using the old carry), then carry_q=0 and bit_cnt=0.
REQ-032 Reset test: assert rst asynchronously between edges during a serial add -> all registered outputs 0 immediately; after release, 1+0 gives sum_q=1.
REQ-033 Wrap test: with CNT_W=2, apply 5 serial in_valid beats -> bit_cnt sequence 1, 2, 3, 0, 1.
REQ-034 Gap test: in parallel mode, idle cycles with in_valid=0 -> out_valid=0 and sum_q/cout_q held.
